// File: rtl/riscv_wb_pkg.sv
// Shared types for the register-file writeback block: load funct3 encodings,
// writeback FSM states, load-queue entry layout and the load extraction helper.
package riscv_wb_pkg;

  localparam int WB_XLEN     = 32;
  localparam int WB_REG_AW   = 5;
  localparam int WB_LQ_DEPTH = 4;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic [2:0]           funct3;
    logic [1:0]           off;
  } lq_entry_t;

  // Pick the addressed byte/half out of the aligned word and extend it.
  // lw and any undefined funct3 return the word untouched.
  function automatic logic [WB_XLEN-1:0] load_extend(
    input logic [2:0]         funct3,
    input logic [1:0]         off,
    input logic [WB_XLEN-1:0] rdata
  );
    logic [7:0]  b8;
    logic [15:0] h16;
    case (off)
      2'd0:    b8 = rdata[7:0];
      2'd1:    b8 = rdata[15:8];
      2'd2:    b8 = rdata[23:16];
      default: b8 = rdata[31:24];
    endcase
    h16 = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LD_LB:   load_extend = {{(WB_XLEN-8){b8[7]}}, b8};
      LD_LH:   load_extend = {{(WB_XLEN-16){h16[15]}}, h16};
      LD_LBU:  load_extend = {{(WB_XLEN-8){1'b0}}, b8};
      LD_LHU:  load_extend = {{(WB_XLEN-16){1'b0}}, h16};
      default: load_extend = rdata;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_queue.sv
// In-order FIFO of outstanding load descriptors. clear wins over push/pop;
// push into a full queue and pop from an empty one are ignored.
module wb_load_queue
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = WB_LQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  lq_entry_t                push_data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output lq_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  lq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != DEPTH_C) && !clear_i;
  assign do_pop  = pop_i  && (count_q != '0)      && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port driver: merges ALU results with in-order load responses,
// tracks registers awaiting loads. Define WB_BYPASS_EN to add the fwd_* forwarding outputs.
module regfile_writeback
  import riscv_wb_pkg::*;
#(
  parameter int XLEN     = WB_XLEN,
  parameter int REG_AW   = WB_REG_AW,
  parameter int LQ_DEPTH = WB_LQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_issue,
  output logic                     ld_ready,
  input  logic [REG_AW-1:0]        ld_rd,
  input  logic [2:0]               ld_funct3,
  input  logic [1:0]               ld_off,
  input  logic                     mem_rvalid,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     flush,
  output logic                     reg_write,
  output logic [REG_AW-1:0]        write_reg,
  output logic [XLEN-1:0]          write_data,
  output logic [(1<<REG_AW)-1:0]   busy,
  output logic                     wb_err,
`ifdef WB_BYPASS_EN
  output logic                     fwd_valid,
  output logic [REG_AW-1:0]        fwd_rd,
  output logic [XLEN-1:0]          fwd_data,
`endif
  output wb_state_t                dbg_state
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  wb_state_t                 state_q, state_d;
  logic [CW-1:0]             drop_q, drop_d;
  logic [(1<<REG_AW)-1:0]    busy_q, busy_d;
  logic                      reg_write_q, reg_write_d;
  logic [REG_AW-1:0]         write_reg_q, write_reg_d;
  logic [XLEN-1:0]           write_data_q, write_data_d;
  logic                      wb_err_q, wb_err_d;

  lq_entry_t                 head;
  lq_entry_t                 push_entry;
  logic [CW-1:0]             count;
  logic                      retire, stray, drained, issue, flush_pend, alu_take;

  // Handshakes: a transfer happens on a cycle where valid (alu_valid / ld_issue)
  // and ready (alu_ready / ld_ready) are both high; the source holds its
  // payload stable until then. mem_rvalid has no ready and is always consumed.
  assign alu_ready  = !(mem_rvalid && (state_q != DRAIN));
  assign ld_ready   = (count < DEPTH_C) && !busy_q[ld_rd] && !flush && (state_q != DRAIN);

  assign retire     = mem_rvalid && (state_q == PENDING);
  assign stray      = mem_rvalid && (state_q == IDLE);
  assign drained    = mem_rvalid && (state_q == DRAIN);
  assign issue      = ld_issue && ld_ready;
  assign flush_pend = flush && (state_q == PENDING);
  assign alu_take   = alu_valid && alu_ready;

  assign push_entry = '{rd: ld_rd, funct3: ld_funct3, off: ld_off};

  wb_load_queue #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (issue),
    .push_data_i (push_entry),
    .pop_i       (retire),
    .clear_i     (flush_pend),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (issue) state_d = PENDING;
      end
      PENDING: begin
        if (flush_pend) begin
          // A response landing with the flush retires normally, so it is not dropped.
          drop_d  = count - CW'(retire);
          state_d = (drop_d == '0) ? IDLE : DRAIN;
        end else if (retire && (count == ONE_C) && !issue) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (drained) begin
          drop_d = drop_q - ONE_C;
          if (drop_q == ONE_C) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (retire) busy_d[head.rd] = 1'b0;
    if (issue)  busy_d[ld_rd]   = 1'b1;
    if (flush_pend) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Loads win the port; x0 targets are consumed without raising reg_write.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (retire) begin
      reg_write_d  = (head.rd != '0);
      write_reg_d  = head.rd;
      write_data_d = load_extend(head.funct3, head.off, mem_rdata);
    end else if (alu_take) begin
      reg_write_d  = (alu_rd != '0);
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end
    wb_err_d = wb_err_q | stray;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drop_q       <= '0;
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
  assign wb_err     = wb_err_q;
  assign dbg_state  = state_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = reg_write_d;
  assign fwd_rd    = write_reg_d;
  assign fwd_data  = write_data_d;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a queue-based model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_regfile_writeback;
  import riscv_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy;
  logic        wb_err;
  wb_state_t   dbg_state;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  regfile_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_issue   (ld_issue),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_off     (ld_off),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .busy       (busy),
    .wb_err     (wb_err),
`ifdef WB_BYPASS_EN
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
`endif
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } ld_t;

  ld_t         pend_q[$];
  int          drop_n;
  bit          m_err;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  function automatic logic [31:0] model_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256   : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic wb_state_t m_state();
    if (drop_n > 0) return DRAIN;
    if (pend_q.size() > 0) return PENDING;
    return IDLE;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    foreach (pend_q[i]) if (pend_q[i].rd != 0) b[pend_q[i].rd] = 1'b1;
    return b;
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic        s_rst, s_alu_v, s_ld_issue, s_rv, s_flush;
  logic [4:0]  s_alu_rd, s_ld_rd;
  logic [31:0] s_alu_data, s_rdata;
  logic [2:0]  s_f3;
  logic [1:0]  s_off;
  always @(posedge clk) begin
    s_rst      <= rst;
    s_alu_v    <= alu_valid;
    s_alu_rd   <= alu_rd;
    s_alu_data <= alu_data;
    s_ld_issue <= ld_issue;
    s_ld_rd    <= ld_rd;
    s_f3       <= ld_funct3;
    s_off      <= ld_off;
    s_rv       <= mem_rvalid;
    s_rdata    <= mem_rdata;
    s_flush    <= flush;
  end

  // ---------------- compare process ----------------
  initial begin
    wb_state_t   st, stc;
    logic [31:0] bz;
    bit          ld_ok, alu_ok;
    ld_t         e;
    forever begin
      @(negedge clk);
      #1;
      if (rst || s_rst) begin
        pend_q.delete();
        drop_n = 0;
        m_err  = 1'b0;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
      end else begin
        st     = m_state();
        bz     = m_busy();
        alu_ok = !(s_rv && st != DRAIN);
        ld_ok  = (pend_q.size() < 4) && !bz[s_ld_rd] && !s_flush && (st != DRAIN);
        m_we   = 1'b0;
        if (s_rv && st == IDLE) m_err = 1'b1;
        if (s_rv && st == DRAIN) drop_n--;
        if (s_rv && st == PENDING) begin
          e      = pend_q.pop_front();
          m_we   = (e.rd != 0);
          m_reg  = e.rd;
          m_data = model_extract(e.f3, e.off, s_rdata);
        end else if (s_alu_v && alu_ok) begin
          m_we   = (s_alu_rd != 0);
          m_reg  = s_alu_rd;
          m_data = s_alu_data;
        end
        if (s_ld_issue && ld_ok) pend_q.push_back('{rd: s_ld_rd, f3: s_f3, off: s_off});
        if (s_flush && st == PENDING) begin
          drop_n = pend_q.size();
          pend_q.delete();
        end

        chk("m_reg_write", reg_write, m_we);
        if (m_we) begin
          chk("m_write_reg", write_reg, m_reg);
          chk("m_write_data", write_data, m_data);
        end
        chk("m_busy", busy, m_busy());
        chk("m_wb_err", wb_err, m_err);
        chk("m_state", 32'(dbg_state), 32'(m_state()));
        stc = m_state();
        bz  = m_busy();
        chk("m_alu_ready", alu_ready, !(mem_rvalid && stc != DRAIN));
        chk("m_ld_ready", ld_ready,
            (pend_q.size() < 4) && !bz[ld_rd] && !flush && (stc != DRAIN));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_off = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;
  endtask

  task automatic alu_write(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    #1 chk("alu_ready_free", alu_ready, 1'b1);
    @(negedge clk);
    alu_valid = 1'b0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_off = off;
    #1 chk("ld_ready_issue", ld_ready, 1'b1);
    @(negedge clk);
    ld_issue = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [4:0] rd, input logic [31:0] d);
    chk({name, "_we"}, reg_write, 1'b1);
    chk({name, "_reg"}, write_reg, rd);
    chk({name, "_data"}, write_data, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_write_reg", write_reg, 5'd0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_wb_err", wb_err, 1'b0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // ALU write, then a write to x0
    alu_write(5'd1, 32'hDEADBEEF);
    expect_write("alu_x1", 5'd1, 32'hDEADBEEF);
    alu_write(5'd0, 32'hFFFFFFFF);
    chk("alu_x0_no_write", reg_write, 1'b0);

    // byte/half extraction
    issue_load(5'd5, LD_LB, 2'd3);
    chk("lb_busy_set", busy[5], 1'b1);
    @(negedge clk);
    chk("lb_busy_hold", busy[5], 1'b1);
    respond(32'h80123456);
    expect_write("lb", 5'd5, 32'hFFFFFF80);
    chk("lb_busy_clr", busy[5], 1'b0);
    issue_load(5'd5, LD_LBU, 2'd3);
    respond(32'h80123456);
    expect_write("lbu", 5'd5, 32'h00000080);
    issue_load(5'd5, LD_LH, 2'd2);
    respond(32'h80123456);
    expect_write("lh", 5'd5, 32'hFFFF8012);
    issue_load(5'd6, LD_LHU, 2'd0);
    respond(32'h80123456);
    expect_write("lhu", 5'd6, 32'h00003456);
    issue_load(5'd7, LD_LW, 2'd1);
    respond(32'h80123456);
    expect_write("lw", 5'd7, 32'h80123456);

    // fill the queue, then hazards
    for (int i = 1; i <= 4; i++) issue_load(5'(i), LD_LW, 2'd0);
    chk("full_busy", busy, 32'h0000001E);
    ld_rd = 5'd7;
    #1 chk("full_ld_ready", ld_ready, 1'b0);
    @(negedge clk);
    respond(32'h11111111);
    expect_write("order1", 5'd1, 32'h11111111);
    ld_rd = 5'd3;
    #1 chk("waw_ld_ready", ld_ready, 1'b0);
    @(negedge clk);
    ld_rd = 5'd9;
    #1 chk("free_ld_ready", ld_ready, 1'b1);
    @(negedge clk);
    for (int i = 2; i <= 4; i++) begin
      respond({8{4'(i)}});
      expect_write("order", 5'(i), {8{4'(i)}});
    end
    chk("drained_busy", busy, 32'h0);

    // issue and retire in the same cycle
    issue_load(5'd20, LD_LW, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h000000FF;
    ld_issue = 1'b1; ld_rd = 5'd21; ld_funct3 = LD_LB; ld_off = 2'd0;
    #1 chk("swap_ld_ready", ld_ready, 1'b1);
    @(negedge clk);
    mem_rvalid = 1'b0; ld_issue = 1'b0;
    expect_write("swap_x20", 5'd20, 32'h000000FF);
    chk("swap_busy", busy, 32'h00200000);
    respond(32'h000000FF);
    expect_write("swap_x21", 5'd21, 32'hFFFFFFFF);

    // load beats ALU
    issue_load(5'd8, LD_LW, 2'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h12345678;
    #1 chk("arb_alu_ready", alu_ready, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    expect_write("arb_load", 5'd8, 32'hCAFEF00D);
    #1 chk("arb_alu_ready_again", alu_ready, 1'b1);
    @(negedge clk);
    alu_valid = 1'b0;
    expect_write("arb_alu", 5'd9, 32'h12345678);

    // flush with two loads pending
    issue_load(5'd10, LD_LW, 2'd0);
    issue_load(5'd11, LD_LW, 2'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 32'h0);
    chk("flush_state", 32'(dbg_state), 32'(DRAIN));
    respond(32'hAAAAAAAA);
    chk("drain1_no_write", reg_write, 1'b0);
    respond(32'hBBBBBBBB);
    chk("drain2_no_write", reg_write, 1'b0);
    chk("drain_idle", 32'(dbg_state), 32'(IDLE));
    chk("drain_no_err", wb_err, 1'b0);
    respond(32'hCCCCCCCC);
    chk("stray_err", wb_err, 1'b1);
    chk("stray_no_write", reg_write, 1'b0);

    // flush together with a response
    issue_load(5'd12, LD_LW, 2'd0);
    issue_load(5'd13, LD_LW, 2'd0);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b0;
    expect_write("flush_retire", 5'd12, 32'h55555555);
    chk("flush_retire_state", 32'(dbg_state), 32'(DRAIN));
    respond(32'h66666666);
    chk("flush_drop", reg_write, 1'b0);
    chk("flush_drop_idle", 32'(dbg_state), 32'(IDLE));

    // asynchronous reset with a load outstanding
    issue_load(5'd14, LD_LW, 2'd0);
    #2 rst = 1'b1;
    #1 chk("arst_busy", busy, 32'h0);
    chk("arst_err", wb_err, 1'b0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    respond(32'h77777777);
    chk("arst_stray_err", wb_err, 1'b1);
    chk("arst_stray_no_write", reg_write, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
